harmonic_note_player: RTL and testbench

Parametrised successor to the single-note player: plays one note from the frequency ROM as a weighted sum of NUM_HARMONICS true harmonics (f, 2f, 3f, ...), counts its duration in beats, and reports busy/done status to the note distributor. It sits between the note distributor and the codec mixer, one instance per voice. It adds two things the earlier player lacked: sustain-until-reload notes and silent rests.

---
 rtl/harmonic_note_player.sv | 263 ++++++++++++++++++++++++++
 tb/tb_harmonic_note_player.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_note_player.sv
// harmonic_note_player: one voice. Plays a frequency-ROM note as a weighted
// sum of NUM_HARMONICS true harmonics (f, 2f, 3f, ...), counts its duration
// in beats and reports busy/done status.
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   play_enable_i             1: run, 0: pause (beats and requests ignored)
//   note_to_load_i[5:0]       frequency ROM address, 0 = rest
//   duration_to_load_i        note length in beats, 0 = sustain until reload
//   load_new_note_i           strobe capturing note and duration
//   beat_i                    1/48 s tick
//   generate_next_sample_i    codec sample request
//   sample_out_o              signed mixed sample (registered)
//   new_sample_ready_o        pulse when sample_out_o updates
//   playing_o                 voice busy
//   done_with_note_o          pulse when the note ends
// Optional feature: define HARMONIC_NOTE_PLAYER_RELEASE_EN for a linear
// release envelope (gain 16 -> 0 in steps of 2 per beat) after the note ends.
module harmonic_note_player #(
  parameter int unsigned NUM_HARMONICS = 3,
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned DUR_WIDTH     = 6
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           play_enable_i,
  input  logic [5:0]                     note_to_load_i,
  input  logic [DUR_WIDTH-1:0]           duration_to_load_i,
  input  logic                           load_new_note_i,
  input  logic                           beat_i,
  input  logic                           generate_next_sample_i,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out_o,
  output logic                           new_sample_ready_o,
  output logic                           playing_o,
  output logic                           done_with_note_o
);

  localparam int unsigned STEP_W  = 20;
  localparam int unsigned PHASE_W = 22;
  localparam int unsigned MIX_W   = SAMPLE_WIDTH + 2;
  localparam int unsigned SH_L    = (SAMPLE_WIDTH >= 16) ? SAMPLE_WIDTH - 16 : 0;
  localparam int unsigned SH_R    = (SAMPLE_WIDTH < 16) ? 16 - SAMPLE_WIDTH : 0;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_RELEASE = 2'd2} state_e;

  // Equal-tempered ROM: note 1 = 55 Hz, 22-bit phase at 48 kHz; octaves by shift.
  function automatic logic [STEP_W-1:0] frequency_rom(input logic [5:0] note);
    logic [5:0]  idx;
    logic [2:0]  oct;
    logic [3:0]  semi;
    logic [13:0] base;
    idx  = note - 6'd1;
    oct  = 3'(idx / 6'd12);
    semi = 4'(idx % 6'd12);
    case (semi)
      4'd1:    base = 14'd5092;
      4'd2:    base = 14'd5395;
      4'd3:    base = 14'd5715;
      4'd4:    base = 14'd6055;
      4'd5:    base = 14'd6415;
      4'd6:    base = 14'd6797;
      4'd7:    base = 14'd7201;
      4'd8:    base = 14'd7629;
      4'd9:    base = 14'd8083;
      4'd10:   base = 14'd8563;
      4'd11:   base = 14'd9073;
      default: base = 14'd4806;
    endcase
    if (note == 6'd0) return '0;
    return STEP_W'(base) << oct;
  endfunction

  // 64-point sine from a 16-entry quarter table (mid-bin samples, Q15).
  function automatic logic signed [SAMPLE_WIDTH-1:0] sine_lut(input logic [5:0] ph);
    logic [3:0]         idx;
    logic [14:0]        mag;
    logic signed [31:0] v;
    idx = ph[4] ? ~ph[3:0] : ph[3:0];
    case (idx)
      4'd0:    mag = 15'd1608;
      4'd1:    mag = 15'd4808;
      4'd2:    mag = 15'd7962;
      4'd3:    mag = 15'd11039;
      4'd4:    mag = 15'd14010;
      4'd5:    mag = 15'd16846;
      4'd6:    mag = 15'd19519;
      4'd7:    mag = 15'd22005;
      4'd8:    mag = 15'd24279;
      4'd9:    mag = 15'd26319;
      4'd10:   mag = 15'd28106;
      4'd11:   mag = 15'd29621;
      4'd12:   mag = 15'd30852;
      4'd13:   mag = 15'd31785;
      4'd14:   mag = 15'd32413;
      default: mag = 15'd32728;
    endcase
    v = $signed({17'd0, mag});
    if (ph[5]) v = -v;
    v = (v <<< SH_L) >>> SH_R;
    return SAMPLE_WIDTH'(v);
  endfunction

  state_e                         state_q, state_d;
  logic [5:0]                     note_q, note_d;
  logic [DUR_WIDTH-1:0]           count_q, count_d;
  logic                           playing_q, playing_d;
  logic                           done_q, done_d;
  logic [STEP_W-1:0]              step_q;
  logic signed [SAMPLE_WIDTH-1:0] sample_q;
  logic                           ready_q;
  logic                           req_c;
  logic [NUM_HARMONICS-1:0]       rdy_c;
  logic signed [SAMPLE_WIDTH-1:0] smp_c [NUM_HARMONICS];
  logic signed [MIX_W-1:0]        sum_c;
  logic signed [SAMPLE_WIDTH-1:0] mix_c;
  logic signed [SAMPLE_WIDTH-1:0] out_c;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
  localparam int unsigned SCL_W = SAMPLE_WIDTH + 6;
  logic [4:0]              gain_q, gain_d;
  logic signed [SCL_W-1:0] scaled_c;
`endif

  assign req_c = generate_next_sample_i & play_enable_i;

  // One sine reader per harmonic; all share the request so they are ready together.
  for (genvar h = 0; h < NUM_HARMONICS; h++) begin : g_reader
    logic [STEP_W-1:0]              hstep_c;
    logic [PHASE_W-1:0]             phase_q;
    logic signed [SAMPLE_WIDTH-1:0] smp_q;
    logic                           rdy_q;
    assign hstep_c  = STEP_W'(step_q * (h + 1));
    assign smp_c[h] = smp_q;
    assign rdy_c[h] = rdy_q;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        phase_q <= '0;
        smp_q   <= '0;
        rdy_q   <= 1'b0;
      end else begin
        rdy_q <= req_c;
        if (req_c) begin
          phase_q <= phase_q + PHASE_W'(hstep_c);
          smp_q   <= sine_lut(phase_q[PHASE_W-1 -: 6]);
        end
      end
    end
  end

  // Weighted mix with saturation; rests and idle voices are silent.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_HARMONICS; k++) begin
      sum_c = sum_c + ($signed(MIX_W'(smp_c[k])) >>> (k + 1));
    end
    if (sum_c[MIX_W-1] && !(&sum_c[MIX_W-2:SAMPLE_WIDTH-1])) begin
      mix_c = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    end else if (!sum_c[MIX_W-1] && (|sum_c[MIX_W-2:SAMPLE_WIDTH-1])) begin
      mix_c = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end else begin
      mix_c = sum_c[SAMPLE_WIDTH-1:0];
    end
    if (note_q == 6'd0 || !playing_q) mix_c = '0;
  end

  // Envelope scaling (unity when the release feature is absent).
  always_comb begin
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
    scaled_c = SCL_W'(mix_c) * SCL_W'($signed({1'b0, gain_q}));
    out_c    = SAMPLE_WIDTH'(scaled_c >>> 4);
`else
    out_c = mix_c;
`endif
  end

  // Note/duration state machine: next-state and status decode.
  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    count_d   = count_q;
    playing_d = playing_q;
    done_d    = 1'b0;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
    gain_d    = gain_q;
`endif
    if (load_new_note_i) begin
      // A load always wins over a coincident beat.
      state_d   = ST_PLAY;
      note_d    = note_to_load_i;
      count_d   = duration_to_load_i;
      playing_d = 1'b1;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
      gain_d    = 5'd16;
`endif
    end else if (play_enable_i && beat_i) begin
      unique case (state_q)
        ST_PLAY: begin
          // count == 0 is sustain: beats are ignored.
          if (count_q > DUR_WIDTH'(1)) begin
            count_d = count_q - DUR_WIDTH'(1);
          end else if (count_q == DUR_WIDTH'(1)) begin
            count_d = '0;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
            state_d = ST_RELEASE;
`else
            state_d   = ST_IDLE;
            playing_d = 1'b0;
            done_d    = 1'b1;
`endif
          end
        end
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
        ST_RELEASE: begin
          gain_d = gain_q - 5'd2;
          if (gain_q <= 5'd2) begin
            gain_d    = '0;
            state_d   = ST_IDLE;
            playing_d = 1'b0;
            done_d    = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      note_q    <= '0;
      count_q   <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= '0;
      sample_q  <= '0;
      ready_q   <= 1'b0;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
      gain_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      count_q   <= count_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      step_q    <= frequency_rom(note_q);
      ready_q   <= 1'b0;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
      gain_q    <= gain_d;
`endif
      // A sample in flight when pause begins is dropped, keeping the output frozen.
      if ((&rdy_c) && play_enable_i) begin
        sample_q <= out_c;
        ready_q  <= 1'b1;
      end
    end
  end

  assign sample_out_o       = sample_q;
  assign new_sample_ready_o = ready_q;
  assign playing_o          = playing_q;
  assign done_with_note_o   = done_q;

endmodule

// File: tb/tb_harmonic_note_player.sv
// Self-checking bench for harmonic_note_player: scenario tasks with a sample
// scoreboard (expected values queued at request time, compared on delivery).
module tb_harmonic_note_player;

  localparam int unsigned SW = 16;
  localparam int unsigned DW = 6;
`ifdef HARMONIC_NOTE_PLAYER_RELEASE_EN
  localparam int REL = 8;
`else
  localparam int REL = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 pen = 1'b1;
  logic [5:0]           note = '0;
  logic [DW-1:0]        dur = '0;
  logic                 load = 1'b0;
  logic                 beat = 1'b0;
  logic                 gen = 1'b0;
  logic signed [SW-1:0] sample_out;
  logic                 nsr;
  logic                 playing;
  logic                 done;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned done_cnt = 0;
  logic signed [SW-1:0] obs_q[$];
  logic signed [SW-1:0] exp_q[$];

  harmonic_note_player dut (
    .clk_i                  (clk),
    .reset_i                (reset),
    .play_enable_i          (pen),
    .note_to_load_i         (note),
    .duration_to_load_i     (dur),
    .load_new_note_i        (load),
    .beat_i                 (beat),
    .generate_next_sample_i (gen),
    .sample_out_o           (sample_out),
    .new_sample_ready_o     (nsr),
    .playing_o              (playing),
    .done_with_note_o       (done)
  );

  always #5 clk = ~clk;

  // Advance one clock, then record what the DUT produced at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (nsr) obs_q.push_back(sample_out);
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic load_note(input logic [5:0] n, input logic [DW-1:0] d);
    note = n;
    dur  = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic request(input logic signed [SW-1:0] expv, input bit push);
    gen = 1'b1;
    if (push) exp_q.push_back(expv);
    tick();
    gen = 1'b0;
    repeat (3) tick();
  endtask

  task automatic finish_release();
    repeat (REL) begin
      tick();
      do_beat();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++; if (sample_out !== '0) $display("FAIL reset_sample: got %0d want 0", sample_out); else n_pass++;
    n_checks++; if (nsr !== 1'b0) $display("FAIL reset_ready: got %b want 0", nsr); else n_pass++;
    n_checks++; if (playing !== 1'b0) $display("FAIL reset_playing: got %b want 0", playing); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  // Phases start at 0 after reset; note 30 has step 25660 (6415 << 2).
  task automatic test_harmonics();
    obs_q.delete();
    exp_q.delete();
    load_note(6'd30, '0);
    repeat (2) tick();
    request(16'sd1407, 1'b1);
    request(16'sd1807, 1'b1);
    request(16'sd3001, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL harm_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic signed [SW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL harm_sample: got %0d want %0d", o, e); else n_pass++;
    end
  endtask

  task automatic test_duration();
    int unsigned d0;
    d0 = done_cnt;
    load_note(6'd20, DW'(3));
    n_checks++; if (playing !== 1'b1) $display("FAIL dur_rise: got %b want 1", playing); else n_pass++;
    for (int b = 0; b < 3; b++) begin
      repeat (99) tick();
      if (b == 2) begin
        n_checks++;
        if (playing !== 1'b1 || done_cnt != d0) $display("FAIL dur_mid: playing %b dones %0d want 1 %0d", playing, done_cnt, d0);
        else n_pass++;
      end
      do_beat();
    end
    finish_release();
    n_checks++; if (done !== 1'b1) $display("FAIL dur_done: got %b want 1", done); else n_pass++;
    n_checks++; if (playing !== 1'b0) $display("FAIL dur_fall: got %b want 0", playing); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0 || done_cnt != d0 + 1) $display("FAIL dur_once: done %b count %0d want 0 %0d", done, done_cnt, d0 + 1); else n_pass++;
  endtask

  task automatic test_sustain();
    int unsigned d0;
    d0 = done_cnt;
    load_note(6'd5, '0);
    repeat (200) begin
      do_beat();
      tick();
    end
    n_checks++;
    if (playing !== 1'b1 || done_cnt != d0) $display("FAIL sustain_hold: playing %b dones %0d want 1 %0d", playing, done_cnt, d0);
    else n_pass++;
    load_note(6'd5, DW'(2));
    do_beat();
    tick();
    n_checks++; if (playing !== 1'b1) $display("FAIL sustain_reload_mid: got %b want 1", playing); else n_pass++;
    do_beat();
    finish_release();
    n_checks++; if (done !== 1'b1 || playing !== 1'b0) $display("FAIL sustain_end: done %b playing %b want 1 0", done, playing); else n_pass++;
  endtask

  task automatic test_rest();
    obs_q.delete();
    exp_q.delete();
    load_note(6'd0, DW'(2));
    repeat (10) request('0, 1'b1);
    do_beat();
    n_checks++; if (playing !== 1'b1) $display("FAIL rest_playing: got %b want 1", playing); else n_pass++;
    do_beat();
    finish_release();
    n_checks++; if (done !== 1'b1) $display("FAIL rest_done: got %b want 1", done); else n_pass++;
    repeat (2) request('0, 1'b1);
    n_checks++;
    if (obs_q.size() != 12) $display("FAIL rest_count: got %0d want 12", obs_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic signed [SW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL rest_sample: got %0d want %0d", o, e); else n_pass++;
    end
  endtask

  task automatic test_collision();
    int unsigned d0;
    d0 = done_cnt;
    load_note(6'd10, DW'(4));
    tick();
    do_beat();
    tick();
    note = 6'd10; dur = DW'(3); load = 1'b1; beat = 1'b1;
    tick();
    load = 1'b0; beat = 1'b0;
    do_beat();
    do_beat();
    n_checks++;
    if (playing !== 1'b1 || done_cnt != d0) $display("FAIL coll_restart: playing %b dones %0d want 1 %0d", playing, done_cnt, d0);
    else n_pass++;
    // Count is 1 here: a coincident load must suppress the done pulse.
    note = 6'd10; dur = DW'(2); load = 1'b1; beat = 1'b1;
    tick();
    load = 1'b0; beat = 1'b0;
    n_checks++;
    if (done !== 1'b0 || playing !== 1'b1) $display("FAIL coll_last_beat: done %b playing %b want 0 1", done, playing);
    else n_pass++;
    do_beat();
    n_checks++; if (playing !== 1'b1) $display("FAIL coll_mid: got %b want 1", playing); else n_pass++;
    do_beat();
    finish_release();
    n_checks++;
    if (done !== 1'b1 || done_cnt != d0 + 1) $display("FAIL coll_end: done %b dones %0d want 1 %0d", done, done_cnt, d0 + 1);
    else n_pass++;
  endtask

  task automatic test_pause();
    int unsigned d0;
    logic signed [SW-1:0] held;
    d0 = done_cnt;
    load_note(6'd30, DW'(4));
    repeat (3) request('0, 1'b0);
    do_beat();
    tick();
    obs_q.delete();
    held = sample_out;
    pen = 1'b0;
    repeat (5) begin
      do_beat();
      gen = 1'b1;
      tick();
      gen = 1'b0;
      tick();
    end
    n_checks++; if (obs_q.size() != 0) $display("FAIL pause_ready: got %0d pulses want 0", obs_q.size()); else n_pass++;
    n_checks++; if (sample_out !== held) $display("FAIL pause_hold: got %0d want %0d", sample_out, held); else n_pass++;
    n_checks++;
    if (playing !== 1'b1 || done_cnt != d0) $display("FAIL pause_count: playing %b dones %0d want 1 %0d", playing, done_cnt, d0);
    else n_pass++;
    pen = 1'b1;
    do_beat();
    do_beat();
    n_checks++; if (playing !== 1'b1) $display("FAIL resume_mid: got %b want 1", playing); else n_pass++;
    do_beat();
    finish_release();
    n_checks++; if (done !== 1'b1) $display("FAIL resume_end: got %b want 1", done); else n_pass++;
  endtask

  task automatic test_reset_mid_note();
    int unsigned d0;
    d0 = done_cnt;
    load_note(6'd30, DW'(5));
    repeat (2) request('0, 1'b0);
    do_beat();
    reset = 1'b1;
    tick();
    n_checks++;
    if (sample_out !== '0 || nsr !== 1'b0 || playing !== 1'b0 || done !== 1'b0)
      $display("FAIL midreset_outputs: sample %0d ready %b playing %b done %b want all 0", sample_out, nsr, playing, done);
    else n_pass++;
    reset = 1'b0;
    repeat (5) tick();
    do_beat();
    tick();
    n_checks++;
    if (done_cnt != d0 || playing !== 1'b0) $display("FAIL midreset_nodone: dones %0d playing %b want %0d 0", done_cnt, playing, d0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_harmonics();
    test_duration();
    test_sustain();
    test_rest();
    test_collision();
    test_pause();
    test_reset_mid_note();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
